memory_access: RTL and testbench
================================

# memory_access

Pipeline MEM stage of the MIPS core: it consumes the registered EX/MEM outputs of the execute stage, performs byte, halfword and word loads and stores against a private word-organised data memory, and produces the MEM/WB pipeline register consumed by write-back. On reset it first sweeps the data memory to zero and holds the pipeline off with `o_busy`. A registered debug read port exposes memory words to the debug unit.

## Interface
Parameters:
- NB_DATA, 32, datapath width.
- NB_ADDR, 8, word-index width; memory depth is 2^NB_ADDR words.

Ports (clock and reset first):
- clk  in  1  single clock, all state on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_halt  in  1  freezes all state: no memory write, outputs hold.
- i_alu_result  in  NB_DATA  byte address for loads and stores; pass-through value for ALU instructions.
- i_data4Mem  in  NB_DATA  store data, already forwarded upstream.
- i_memRead  in  1  load enable.
- i_memWrite  in  1  store enable.
- i_mem2reg  in  1  write-back select, passed through.
- i_regWrite  in  1  register-file write enable, passed through.
- i_write_reg  in  5  destination register, passed through.
- i_width  in  2  access width: 00 byte, 01 halfword, 1x word.
- i_sign_flag  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- i_dbg_addr  in  NB_ADDR  debug word index.
- o_mem2reg  out  1  registered.
- o_regWrite  out  1  registered.
- o_write_reg  out  5  registered.
- o_alu_result  out  NB_DATA  registered copy of i_alu_result.
- o_read_data  out  NB_DATA  registered, extended load data.
- o_busy  out  1  high while the init sweep is running.
- o_dbg_data  out  NB_DATA  registered word at i_dbg_addr.

## Operation
- States: INIT, RUN.
  - Reset enters INIT with the sweep counter at 0.
  - INIT writes 0 to word[counter] each cycle and increments the counter. After the word 2^NB_ADDR−1 is written, the block moves to RUN.
  - RUN is terminal until the next reset.
- i_halt also freezes the sweep counter.
- Word index is i_alu_result[NB_ADDR+1:2]. Higher address bits are ignored, so the index wraps. Byte lane is i_alu_result[1:0]. Little-endian.
- Stores (RUN, i_memWrite, !i_halt):
  - Byte: writes lane addr[1:0] with i_data4Mem[7:0].
  - Halfword: writes lanes {addr[1],0} and {addr[1],1} with i_data4Mem[15:0]; addr[0] is ignored.
  - Word: writes the whole word; addr[1:0] are ignored.
  - Other lanes of the word are unchanged.
- Loads select the same lanes and extend per i_sign_flag. When i_memRead is 0, o_read_data is loaded with 0.
- Pass-through fields are registered unchanged.
- In INIT:
  - Pipeline inputs are ignored: no stores occur.
  - Pass-through registers load 0. o_regWrite is therefore 0, so no bubble reaches write-back.
  - Upstream must stall on o_busy.
- i_memRead and i_memWrite both high: the store is performed, and o_read_data returns the pre-store word.
- Debug port: o_dbg_data is updated every non-halted cycle, including during INIT. A same-cycle store to the same word returns the old value.

## Timing
- All outputs reset to 0 on the edge where i_rst is high, except o_busy, which resets to 1.
- o_busy deasserts on the edge that leaves INIT. The sweep takes exactly 2^NB_ADDR cycles after reset release.
- Load latency is 1 cycle: inputs sampled at edge N appear on o_read_data after edge N.
- A store at edge N is visible to a load sampled at edge N+1.
- Reset mid-sweep or mid-RUN restarts INIT from counter 0. Memory contents are re-zeroed by the sweep, not by the reset itself.
- i_halt high holds every register and memory word. It takes priority over everything except i_rst.

## Structure
- Shared package: width encodings (WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b11) and state constants ST_INIT, ST_RUN.
- One sub-module, `data_memory`: a byte-enable write, asynchronous-read word array of depth 2^NB_ADDR with a second read port for debug.
- Lane select, extension, FSM and pipeline registers live in memory_access.

## Test plan
- Reset, NB_ADDR=4 → o_busy high for exactly 16 cycles, then low. o_regWrite stays 0 throughout. A debug read of word 5 returns 0.
- Word store 0xDEADBEEF @0x10, then word load @0x10 → o_read_data=0xDEADBEEF one cycle after the load is sampled. o_alu_result=0x10.
- Byte store 0x80 @0x11, then byte load @0x11 → 0xFFFFFF80 with i_sign_flag=1 and 0x00000080 with i_sign_flag=0. Word @0x10 reads 0xDEAD80EF.
- Halfword store 0x1234 @0x22, then word load @0x20 → 0x12340000. A halfword load @0x23 returns 0x00001234.
- i_halt high during a store @0x30 → memory unchanged and all outputs hold. Deasserting halt then completes the store.
- i_rst pulsed mid-RUN after stores → o_busy reasserts and the sweep restarts at 0. A subsequent load @0x10 returns 0.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM stage: access-width encodings, FSM states,
// and the lane-enable helper used by both stores and the write port.
package memory_access_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte lanes touched by an access. Width bit 1 set means word (10 and 11
  // both count as word), so only bit 0 separates byte from halfword.
  function automatic logic [3:0] lane_enable(input logic [1:0] width,
                                             input logic [1:0] lane);
    if (width[1])
      return 4'b1111;
    else if (width[0])
      return lane[1] ? 4'b1100 : 4'b0011;
    else
      return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// data_memory: word-organised array with per-byte write enables, an
// asynchronous read port sharing the write address, and a second
// asynchronous read port for the debug unit.
// Ports:
//   clk          clock
//   i_we         write enable
//   i_byte_en    per-byte write enables
//   i_addr       word index for write and primary read
//   i_wdata      write data (already replicated into the enabled lanes)
//   o_rdata      word at i_addr (pre-write value during a write cycle)
//   i_dbg_addr   debug word index
//   o_dbg_rdata  word at i_dbg_addr
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [NB_DATA/8-1:0] i_byte_en,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic [NB_DATA-1:0]   o_rdata,
  input  logic [NB_ADDR-1:0]   i_dbg_addr,
  output logic [NB_DATA-1:0]   o_dbg_rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // No reset: contents are cleared by the sweep in memory_access.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB_DATA/8; b++) begin
        if (i_byte_en[b]) mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata     = mem[i_addr];
  assign o_dbg_rdata = mem[i_dbg_addr];

endmodule

// File: rtl/memory_access.sv
// memory_access: MIPS MEM stage. Performs byte/halfword/word loads and
// stores on a private data memory and registers the MEM/WB fields. After
// reset the memory is swept to zero while o_busy stalls the pipeline.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweep: zero word[sweep_cnt] each cycle, pipeline held at 0
//   ST_RUN  | normal load/store operation, terminal until reset
//
// Ports:
//   clk, i_rst (sync, active high), i_halt (freeze all state)
//   i_alu_result, i_data4Mem, i_memRead, i_memWrite, i_width, i_sign_flag
//   i_mem2reg, i_regWrite, i_write_reg   pass-through control
//   o_mem2reg, o_regWrite, o_write_reg, o_alu_result, o_read_data  MEM/WB
//   o_busy       high while the sweep runs
//   i_dbg_addr / o_dbg_data  registered debug word read
module memory_access
  import memory_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_mem2reg,
  input  logic               i_regWrite,
  input  logic [4:0]         i_write_reg,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_dbg_data
);

  state_t               state, state_next;
  logic [NB_ADDR-1:0]   sweep_cnt;

  logic [NB_ADDR-1:0]   word_idx;
  logic [1:0]           lane;
  logic                 mem_we;
  logic [NB_DATA/8-1:0] mem_be;
  logic [NB_ADDR-1:0]   mem_addr;
  logic [NB_DATA-1:0]   mem_wdata;
  logic [NB_DATA-1:0]   mem_rdata;
  logic [NB_DATA-1:0]   dbg_rdata;
  logic [NB_DATA-1:0]   store_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [NB_DATA-1:0]   load_data;

  assign word_idx = i_alu_result[NB_ADDR+1:2];
  assign lane     = i_alu_result[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (!i_halt) begin
      state <= state_next;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + NB_ADDR'(1);
    end
  end

  // Next state
  always_comb begin
    state_next = state;
    if (state == ST_INIT && sweep_cnt == '1) state_next = ST_RUN;
  end

  // FSM outputs: the memory write port is owned by the sweep during INIT.
  // Writes are blocked on the reset edge itself; reset does not clear memory.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = word_idx;
    mem_wdata = store_data;
    if (state == ST_INIT) begin
      mem_we    = !i_rst && !i_halt;
      mem_be    = '1;
      mem_addr  = sweep_cnt;
      mem_wdata = '0;
    end else begin
      mem_we = !i_rst && !i_halt && i_memWrite;
      mem_be = lane_enable(i_width, lane);
    end
  end

  // Replicate store data across lanes; the byte enables pick the target.
  always_comb begin
    store_data = i_data4Mem;
    if (!i_width[1]) begin
      if (i_width[0]) store_data = {(NB_DATA/16){i_data4Mem[15:0]}};
      else            store_data = {(NB_DATA/8){i_data4Mem[7:0]}};
    end
  end

  data_memory #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_data_memory (
    .clk        (clk),
    .i_we       (mem_we),
    .i_byte_en  (mem_be),
    .i_addr     (mem_addr),
    .i_wdata    (mem_wdata),
    .o_rdata    (mem_rdata),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_rdata(dbg_rdata)
  );

  // Load lane select and extension (read is of the pre-store word).
  assign ld_byte = mem_rdata[{lane, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = mem_rdata;
    if (!i_width[1]) begin
      if (i_width[0])
        load_data = {{(NB_DATA-16){i_sign_flag & ld_half[15]}}, ld_half};
      else
        load_data = {{(NB_DATA-8){i_sign_flag & ld_byte[7]}}, ld_byte};
    end
  end

  // MEM/WB pipeline registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_mem2reg    <= 1'b0;
      o_regWrite   <= 1'b0;
      o_write_reg  <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
      o_busy       <= 1'b1;
      o_dbg_data   <= '0;
    end else if (!i_halt) begin
      o_busy     <= (state_next == ST_INIT);
      o_dbg_data <= dbg_rdata;
      if (state == ST_RUN) begin
        o_mem2reg    <= i_mem2reg;
        o_regWrite   <= i_regWrite;
        o_write_reg  <= i_write_reg;
        o_alu_result <= i_alu_result;
        o_read_data  <= i_memRead ? load_data : '0;
      end else begin
        o_mem2reg    <= 1'b0;
        o_regWrite   <= 1'b0;
        o_write_reg  <= '0;
        o_alu_result <= '0;
        o_read_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 2**NB_ADDR;

  logic               clk = 1'b0;
  logic               i_rst, i_halt;
  logic [NB_DATA-1:0] i_alu_result, i_data4Mem;
  logic               i_memRead, i_memWrite, i_mem2reg, i_regWrite;
  logic [4:0]         i_write_reg;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic               o_mem2reg, o_regWrite, o_busy;
  logic [4:0]         o_write_reg;
  logic [NB_DATA-1:0] o_alu_result, o_read_data, o_dbg_data;

  memory_access #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk(clk), .i_rst(i_rst), .i_halt(i_halt),
    .i_alu_result(i_alu_result), .i_data4Mem(i_data4Mem),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite),
    .i_mem2reg(i_mem2reg), .i_regWrite(i_regWrite),
    .i_write_reg(i_write_reg), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_dbg_addr(i_dbg_addr),
    .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite),
    .o_write_reg(o_write_reg), .o_alu_result(o_alu_result),
    .o_read_data(o_read_data), .o_busy(o_busy), .o_dbg_data(o_dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: byte-addressed memory image plus expected outputs.
  logic [7:0]  mm [DEPTH*4];
  bit          mk [DEPTH];
  bit          m_init;
  int          m_cnt;
  logic        e_m2r, e_rw, e_busy, e_dbg_ok;
  logic [4:0]  e_wreg;
  logic [31:0] e_alu, e_rd, e_dbg;

  function automatic logic [31:0] m_word(int w);
    return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int base, ln, lo;
    logic [31:0] v;
    if (i_rst) begin
      {e_m2r, e_rw, e_wreg, e_alu, e_rd, e_dbg} = '0;
      e_busy = 1'b1; e_dbg_ok = 1'b1;
      m_init = 1'b1; m_cnt = 0;
    end else if (!i_halt) begin
      e_dbg_ok = mk[int'(i_dbg_addr)];
      e_dbg    = m_word(int'(i_dbg_addr));
      if (m_init) begin
        for (int k = 0; k < 4; k++) mm[m_cnt*4+k] = 8'h00;
        mk[m_cnt] = 1'b1;
        m_cnt++;
        if (m_cnt == DEPTH) m_init = 1'b0;
        e_busy = m_init;
        {e_m2r, e_rw, e_wreg, e_alu, e_rd} = '0;
      end else begin
        base = int'((i_alu_result >> 2) % DEPTH) * 4;
        ln   = int'(i_alu_result & 3);
        lo   = base + (i_alu_result[1] ? 2 : 0);
        if (i_width[1]) v = m_word(base / 4);
        else if (i_width[0]) begin
          v = {16'h0, mm[lo+1], mm[lo]};
          if (i_sign_flag && v[15]) v = v | 32'hFFFF0000;
        end else begin
          v = {24'h0, mm[base+ln]};
          if (i_sign_flag && v[7]) v = v | 32'hFFFFFF00;
        end
        e_rd   = i_memRead ? v : 32'h0;
        e_alu  = i_alu_result;
        e_m2r  = i_mem2reg;
        e_rw   = i_regWrite;
        e_wreg = i_write_reg;
        e_busy = 1'b0;
        if (i_memWrite) begin
          if (i_width[1])
            for (int k = 0; k < 4; k++) mm[base+k] = i_data4Mem[k*8 +: 8];
          else if (i_width[0]) begin
            mm[lo] = i_data4Mem[7:0]; mm[lo+1] = i_data4Mem[15:8];
          end else mm[base+ln] = i_data4Mem[7:0];
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("busy",      32'(o_busy),      32'(e_busy));
    check("regWrite",  32'(o_regWrite),  32'(e_rw));
    check("mem2reg",   32'(o_mem2reg),   32'(e_m2r));
    check("write_reg", 32'(o_write_reg), 32'(e_wreg));
    check("alu_result", o_alu_result, e_alu);
    check("read_data",  o_read_data,  e_rd);
    if (e_dbg_ok) check("dbg_data", o_dbg_data, e_dbg);
  endtask

  task automatic op(logic r, logic w, logic [1:0] wd, logic sg,
                    logic [31:0] a, logic [31:0] d);
    i_memRead = r; i_memWrite = w; i_width = wd; i_sign_flag = sg;
    i_alu_result = a; i_data4Mem = d;
    cycle();
  endtask

  initial begin
    int n;
    for (int k = 0; k < DEPTH*4; k++) mm[k] = 8'h00;
    for (int k = 0; k < DEPTH; k++) mk[k] = 1'b0;
    i_rst = 1'b1; i_halt = 1'b0; i_alu_result = '0; i_data4Mem = '0;
    i_memRead = 1'b0; i_memWrite = 1'b0; i_mem2reg = 1'b1; i_regWrite = 1'b1;
    i_write_reg = 5'd7; i_width = 2'b11; i_sign_flag = 1'b0; i_dbg_addr = '0;
    #2;
    cycle();
    cycle();
    i_rst = 1'b0;

    // Sweep length, with regWrite requested upstream the whole time
    n = 0;
    for (int i = 0; i < 40 && o_busy; i++) begin
      cycle();
      n++;
    end
    check("busy_len", 32'(n), 32'd16);

    i_regWrite = 1'b0; i_mem2reg = 1'b0; i_write_reg = 5'd3;
    i_dbg_addr = 4'd5;
    op(0, 0, 2'b11, 0, 32'h0, 32'h0);
    check("dbg_w5_zero", o_dbg_data, 32'h0);

    op(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF);
    op(1, 0, 2'b11, 0, 32'h10, 32'h0);
    check("word_load", o_read_data, 32'hDEADBEEF);
    check("word_alu",  o_alu_result, 32'h10);

    op(0, 1, 2'b00, 0, 32'h11, 32'h00000080);
    op(1, 0, 2'b00, 1, 32'h11, 32'h0);
    check("byte_sext", o_read_data, 32'hFFFFFF80);
    op(1, 0, 2'b00, 0, 32'h11, 32'h0);
    check("byte_zext", o_read_data, 32'h00000080);
    op(1, 0, 2'b11, 0, 32'h10, 32'h0);
    check("word_after_byte", o_read_data, 32'hDEAD80EF);

    op(0, 1, 2'b01, 0, 32'h22, 32'h00001234);
    op(1, 0, 2'b11, 0, 32'h20, 32'h0);
    check("half_word_view", o_read_data, 32'h12340000);
    op(1, 0, 2'b01, 0, 32'h23, 32'h0);
    check("half_load_a0_ignored", o_read_data, 32'h00001234);

    op(1, 1, 2'b11, 0, 32'h10, 32'h11111111);
    check("rw_pre_store", o_read_data, 32'hDEAD80EF);

    i_dbg_addr = 4'd12;
    i_regWrite = 1'b1; i_write_reg = 5'd9;
    i_halt = 1'b1;
    op(0, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D);
    check("halt_hold_read", o_read_data, 32'hDEAD80EF);
    check("halt_hold_regWrite", 32'(o_regWrite), 32'd0);
    cycle();
    i_halt = 1'b0;
    cycle();
    op(1, 0, 2'b11, 0, 32'h30, 32'h0);
    check("halt_then_store", o_read_data, 32'hCAFEF00D);

    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    check("rst_busy", 32'(o_busy), 32'd1);
    op(0, 0, 2'b11, 0, 32'h0, 32'h0);
    n = 1;
    for (int i = 0; i < 40 && o_busy; i++) begin
      cycle();
      n++;
    end
    check("busy_len_rerun", 32'(n), 32'd16);
    op(1, 0, 2'b11, 0, 32'h10, 32'h0);
    check("load_after_rst", o_read_data, 32'h0);

    // Random traffic, including wrapping addresses, halts and resets
    for (int i = 0; i < 600; i++) begin
      i_rst        = ($urandom_range(0, 199) == 0);
      i_halt       = ($urandom_range(0, 7) == 0);
      i_alu_result = $urandom;
      i_data4Mem   = $urandom;
      i_memRead    = $urandom_range(0, 1) == 1;
      i_memWrite   = $urandom_range(0, 2) == 0;
      i_mem2reg    = $urandom_range(0, 1) == 1;
      i_regWrite   = $urandom_range(0, 1) == 1;
      i_write_reg  = 5'($urandom);
      i_width      = 2'($urandom);
      i_sign_flag  = $urandom_range(0, 1) == 1;
      i_dbg_addr   = NB_ADDR'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
